vend_dispense_scheduler: RTL and testbench
==========================================

Name: vend_dispense_scheduler

Overview:
- Shares the machine's single actuator driver (solenoid/motor power stage) between three requesters: candy dispense, soda dispense and 0.25 change eject.
- Latches one-cycle requests from the vending FSM, grants them round-robin, and drives exactly one actuator line for a timed pulse followed by a mandatory cooldown gap.
- Sits between the vending FSM and the board actuator outputs. Timing comes from a slow tick enable derived in the top level.

Parameters:
- PULSE_TICKS, 5, actuator on-time in TICKs; legal range 1..15.
- GAP_TICKS, 2, cooldown after each pulse in TICKs; legal range 0..15 (0 = no gap).
- CNT_W, 4, width of the tick counter; must hold max(PULSE_TICKS, GAP_TICKS)-1.

Ports:
- CLK  input  1  system clock; sole clock of the block.
- RST  input  1  synchronous, active-high reset.
- TICK  input  1  one-CLK-wide timing enable (10 Hz in system; tie high in sim).
- REQ_C  input  1  candy dispense request, one-cycle pulse.
- REQ_S  input  1  soda dispense request, one-cycle pulse.
- REQ_E  input  1  change eject request, one-cycle pulse.
- ACT_C  output  1  candy actuator drive.
- ACT_S  output  1  soda actuator drive.
- ACT_E  output  1  coin eject actuator drive.
- BUSY  output  1  high in FIRE or GAP.
- DONE  output  1  one-cycle pulse when a pulse completes.
- DONE_ID  output  2  id of the completed job (01 C, 10 S, 11 E); valid with DONE.
- PEND  output  3  pending bits {E,S,C}.
- OVR  output  1  sticky: a request arrived while its pending bit was already set.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. All outputs are registered.
- Reset: state=IDLE, counter=0, all ACT_*=0, BUSY=0, DONE=0, DONE_ID=00, PEND=000, OVR=0, rr pointer=E (so C has first priority).
- Pending latch: REQ_x high at a CLK edge sets PEND[x].
  - The set wins over a same-cycle clear by grant.
  - REQ_x while PEND[x] is already 1 is dropped and sets OVR. OVR is cleared only by RST.
  - Simultaneous requests all latch.
- States: IDLE, FIRE, GAP (2-bit encoding).
- IDLE:
  - If PEND != 0, grant the first set bit after the rr pointer in order C->S->E->C.
  - Clear that PEND bit, set the pointer to the grantee, drive its ACT line high next cycle, counter=0, go to FIRE.
  - Grant latency: REQ sampled at edge k -> ACT high after edge k+1.
- FIRE:
  - Exactly one ACT line is high.
  - On each TICK: if counter==PULSE_TICKS-1, drop ACT, pulse DONE with DONE_ID, counter=0, go to GAP (or IDLE if GAP_TICKS==0). Otherwise increment counter.
  - No TICK means hold.
- GAP:
  - All ACT lines low.
  - On each TICK: if counter==GAP_TICKS-1, go to IDLE. Otherwise increment counter.
- Inter-pulse spacing: IDLE always lasts at least one cycle between jobs, so back-to-back grants are spaced by one CLK after GAP.
- Request for the job currently firing: latched as a new pending entry and served again in a later round.
- RST mid-FIRE: ACT drops at that edge. Pending jobs are lost.
- Invariants: ACT_* is at most one-hot; no ACT is ever high in GAP or IDLE.
- BUSY = (state != IDLE). DONE is never asserted on consecutive cycles.

Decomposition:
- Shared package vend_pkg:
  - state encodings IDLE/FIRE/GAP;
  - job id constants ID_C=2'b01, ID_S=2'b10, ID_E=2'b11;
  - default PULSE_TICKS/GAP_TICKS.
- Sub-module rr_arbiter3:
  - combinational three-way round-robin pick;
  - inputs: pending vector and last-grant pointer; output: one-hot grant.
- The FSM, counter and pending/OVR registers stay in vend_dispense_scheduler.

Test Plan:
- TICK=1, defaults, REQ_C at edge 0 -> ACT_C high cycles 2..6; DONE=1, DONE_ID=01 in cycle 7; BUSY cycles 2..8; IDLE at cycle 9.
- REQ_C, REQ_S, REQ_E in the same cycle, TICK=1 -> serviced C, S, E in that order:
  - ACT_C from cycle 2, ACT_S from cycle 10, ACT_E from cycle 18;
  - PEND steps 111->110->100->000.
- REQ_S during the ACT_S pulse -> PEND[S]=1 and OVR stays 0. A second REQ_S before the grant -> OVR=1 and stays set; S is serviced exactly twice total.
- TICK every 4th cycle, PULSE_TICKS=5 -> ACT_C stays high across exactly 5 TICK edges; no ACT change on non-TICK cycles.
- GAP_TICKS=0, REQ_C and REQ_S -> ACT_S rises 1 idle cycle after ACT_C falls; DONE pulses for 01 then 10.
- RST asserted during the 3rd cycle of ACT_E with PEND=011 -> at the next edge ACT_E=0, PEND=000, state IDLE, OVR=0; the next REQ_E is granted with normal 2-cycle latency.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense scheduler.
// Holds the FSM state encodings, the job id codes reported on DONE_ID,
// the default pulse/gap lengths and a one-hot to job-id helper.
package vend_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned JOB_N = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_FIRE = 2'd1;
  localparam logic [ST_W-1:0] ST_GAP  = 2'd2;

  localparam logic [ID_W-1:0] ID_C = 2'b01;
  localparam logic [ID_W-1:0] ID_S = 2'b10;
  localparam logic [ID_W-1:0] ID_E = 2'b11;

  localparam int unsigned DEF_PULSE_TICKS = 5;
  localparam int unsigned DEF_GAP_TICKS   = 2;

  // One-hot job vector {E,S,C} to the reported job id.
  function automatic logic [ID_W-1:0] job_id(input logic [JOB_N-1:0] onehot);
    logic [ID_W-1:0] id;
    case (onehot)
      3'b001:  id = ID_C;
      3'b010:  id = ID_S;
      3'b100:  id = ID_E;
      default: id = 2'b00;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin pick for the dispense scheduler.
// Ports:
//   pend_i    pending vector {E,S,C}
//   last_i    one-hot last grantee {E,S,C}; search starts after it
//   grant_c_o one-hot grant (combinational), zero when nothing pending
module rr_arbiter3
  import vend_pkg::*;
(
  input  logic [JOB_N-1:0] pend_i,
  input  logic [JOB_N-1:0] last_i,
  output logic [JOB_N-1:0] grant_c_o
);

  // Search order is C->S->E->C starting just after the last grantee.
  always_comb begin
    grant_c_o = '0;
    case (last_i)
      3'b001: begin
        if      (pend_i[1]) grant_c_o = 3'b010;
        else if (pend_i[2]) grant_c_o = 3'b100;
        else if (pend_i[0]) grant_c_o = 3'b001;
      end
      3'b010: begin
        if      (pend_i[2]) grant_c_o = 3'b100;
        else if (pend_i[0]) grant_c_o = 3'b001;
        else if (pend_i[1]) grant_c_o = 3'b010;
      end
      default: begin
        if      (pend_i[0]) grant_c_o = 3'b001;
        else if (pend_i[1]) grant_c_o = 3'b010;
        else if (pend_i[2]) grant_c_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Shares one actuator power stage between candy, soda and change eject.
// One-cycle requests are latched as pending bits, granted round-robin, and
// the grantee's actuator line is driven for PULSE_TICKS ticks followed by a
// GAP_TICKS cooldown. All outputs come straight from flops.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   TICK              one-CLK timing enable for pulse/gap counting
//   REQ_C/S/E         one-cycle dispense/eject requests
//   ACT_C/S/E         actuator drives (at most one high)
//   BUSY              high while firing or cooling down
//   DONE, DONE_ID     one-cycle completion pulse and job id (01 C, 10 S, 11 E)
//   PEND              pending bits {E,S,C}
//   OVR               sticky: request seen while already pending
module vend_dispense_scheduler
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_TICKS = DEF_PULSE_TICKS,
  parameter int unsigned GAP_TICKS   = DEF_GAP_TICKS,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       REQ_C,
  input  logic       REQ_S,
  input  logic       REQ_E,
  output logic       ACT_C,
  output logic       ACT_S,
  output logic       ACT_E,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] DONE_ID,
  output logic [2:0] PEND,
  output logic       OVR
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS == 0) ? 32'd0 : GAP_TICKS - 1);
  localparam bit               HAS_GAP    = (GAP_TICKS != 0);

  logic [ST_W-1:0]  state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [JOB_N-1:0] act_q,     act_d;
  logic [JOB_N-1:0] pend_q,    pend_d;
  logic [JOB_N-1:0] ptr_q,     ptr_d;
  logic             ovr_q,     ovr_d;
  logic             done_q,    done_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic             busy_q,    busy_d;

  logic [JOB_N-1:0] req;
  logic [JOB_N-1:0] grant_c;
  logic [JOB_N-1:0] clr;

  assign req = {REQ_E, REQ_S, REQ_C};

  rr_arbiter3 u_arb (
    .pend_i    (pend_q),
    .last_i    (ptr_q),
    .grant_c_o (grant_c)
  );

  // State and output registers; pointer resets to E so C is served first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      act_q     <= '0;
      pend_q    <= '0;
      ptr_q     <= 3'b100;
      ovr_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    clr       = '0;

    case (state_q)
      ST_IDLE: begin
        act_d = '0;
        if (|pend_q) begin
          clr     = grant_c;
          ptr_d   = grant_c;
          act_d   = grant_c;
          cnt_d   = '0;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (TICK) begin
          if (cnt_q == PULSE_LAST) begin
            act_d     = '0;
            done_d    = 1'b1;
            done_id_d = job_id(act_q);
            cnt_d     = '0;
            state_d   = HAS_GAP ? ST_GAP : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        act_d = '0;
        if (TICK) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        act_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // A new request re-sets its bit even when it is being granted this cycle.
    pend_d = (pend_q & ~clr) | req;
    ovr_d  = ovr_q | (|(req & pend_q));
    busy_d = (state_d != ST_IDLE);
  end

  assign ACT_C   = act_q[0];
  assign ACT_S   = act_q[1];
  assign ACT_E   = act_q[2];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign DONE_ID = done_id_q;
  assign PEND    = pend_q;
  assign OVR     = ovr_q;

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Bench for vend_dispense_scheduler: two instances share the stimulus,
// u0 with default timing (5/2) and u1 with PULSE_TICKS=3, GAP_TICKS=0.
// Every cycle both are compared with a job-level reference model; a
// vector table and hand-written sequences pin down the corner cases.
module tb_vend_dispense_scheduler;

  logic CLK = 1'b0;
  logic RST, TICK, REQ_C, REQ_S, REQ_E;

  logic       c0, s0, e0, busy0, done0, ovr0;
  logic [1:0] did0;
  logic [2:0] pend0;
  logic       c1, s1, e1, busy1, done1, ovr1;
  logic [1:0] did1;
  logic [2:0] pend1;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  vend_dispense_scheduler u0 (
    .CLK(CLK), .RST(RST), .TICK(TICK),
    .REQ_C(REQ_C), .REQ_S(REQ_S), .REQ_E(REQ_E),
    .ACT_C(c0), .ACT_S(s0), .ACT_E(e0),
    .BUSY(busy0), .DONE(done0), .DONE_ID(did0), .PEND(pend0), .OVR(ovr0)
  );

  vend_dispense_scheduler #(.PULSE_TICKS(3), .GAP_TICKS(0)) u1 (
    .CLK(CLK), .RST(RST), .TICK(TICK),
    .REQ_C(REQ_C), .REQ_S(REQ_S), .REQ_E(REQ_E),
    .ACT_C(c1), .ACT_S(s1), .ACT_E(e1),
    .BUSY(busy1), .DONE(done1), .DONE_ID(did1), .PEND(pend1), .OVR(ovr1)
  );

  // Reference model: job index 0=C 1=S 2=E, countdown of remaining ticks.
  int         P_OF [2] = '{5, 3};
  int         G_OF [2] = '{2, 0};
  logic [2:0] m_pend [2];
  int         m_last [2];
  int         m_job  [2];
  int         m_on   [2];
  int         m_gap  [2];
  bit         m_ovr  [2];
  bit         m_done [2];
  logic [1:0] m_did  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int m, input logic r, input logic t, input logic [2:0] q);
    logic [2:0] old;
    if (r) begin
      m_pend[m] = '0; m_last[m] = 2; m_job[m] = -1; m_on[m] = 0; m_gap[m] = 0;
      m_ovr[m] = 0; m_done[m] = 0; m_did[m] = '0;
      return;
    end
    old       = m_pend[m];
    m_done[m] = 0;
    if (m_job[m] >= 0) begin
      if (t) begin
        m_on[m]--;
        if (m_on[m] == 0) begin
          m_done[m] = 1;
          m_did[m]  = 2'(m_job[m] + 1);
          m_job[m]  = -1;
          m_gap[m]  = G_OF[m];
        end
      end
    end else if (m_gap[m] > 0) begin
      if (t) m_gap[m]--;
    end else if (old != 0) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last[m] + k) % 3;
        if (old[c]) begin
          m_pend[m][c] = 1'b0;
          m_last[m]    = c;
          m_job[m]     = c;
          m_on[m]      = P_OF[m];
          break;
        end
      end
    end
    for (int x = 0; x < 3; x++) begin
      if (q[x]) begin
        if (old[x]) m_ovr[m] = 1;
        m_pend[m][x] = 1'b1;
      end
    end
  endtask

  task automatic model_check(input int m, input logic [2:0] act, input logic [2:0] pend,
                             input logic busy, input logic done, input logic [1:0] did,
                             input logic ovr);
    logic [2:0] e_act;
    e_act = (m_job[m] >= 0) ? 3'(1 << m_job[m]) : 3'b000;
    chk($sformatf("u%0d.act", m),  32'(act),  32'(e_act));
    chk($sformatf("u%0d.pend", m), 32'(pend), 32'(m_pend[m]));
    chk($sformatf("u%0d.busy", m), 32'(busy), 32'((m_job[m] >= 0) || (m_gap[m] > 0)));
    chk($sformatf("u%0d.done", m), 32'(done), 32'(m_done[m]));
    chk($sformatf("u%0d.ovr", m),  32'(ovr),  32'(m_ovr[m]));
    if (m_done[m]) chk($sformatf("u%0d.done_id", m), 32'(did), 32'(m_did[m]));
  endtask

  // One clock: drive, step the model at the edge, compare at the falling edge.
  task automatic cyc(input logic r, input logic t, input logic [2:0] q);
    RST = r; TICK = t; REQ_C = q[0]; REQ_S = q[1]; REQ_E = q[2];
    @(posedge CLK);
    model_step(0, r, t, q);
    model_step(1, r, t, q);
    @(negedge CLK);
    model_check(0, {e0, s0, c0}, pend0, busy0, done0, did0, ovr0);
    model_check(1, {e1, s1, c1}, pend1, busy1, done1, did1, ovr1);
  endtask

  typedef struct {
    logic       rst;
    logic       tick;
    logic [2:0] req;
    logic [2:0] act;
    logic [2:0] pend;
    logic       busy;
    logic       done;
    logic [1:0] did;
    logic       ovr;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int ticks_hi0, ticks_hi1, bad_chg, s_dones;
    logic [2:0] prev0, prev1;

    RST = 1'b1; TICK = 1'b1; REQ_C = 1'b0; REQ_S = 1'b0; REQ_E = 1'b0;

    // Single candy job on u0, TICK=1: rows are edges -1..10.
    tbl[0]  = '{1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 2'b01, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst, tbl[i].tick, tbl[i].req);
      chk($sformatf("tbl%0d.act", i),  32'({e0, s0, c0}), 32'(tbl[i].act));
      chk($sformatf("tbl%0d.pend", i), 32'(pend0), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d.busy", i), 32'(busy0), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i), 32'(done0), 32'(tbl[i].done));
      if (tbl[i].done) chk($sformatf("tbl%0d.did", i), 32'(did0), 32'(tbl[i].did));
      chk($sformatf("tbl%0d.ovr", i),  32'(ovr0), 32'(tbl[i].ovr));
    end

    // Three simultaneous requests: served C, S, E, eight cycles apart on u0.
    cyc(1'b1, 1'b1, 3'b000);
    cyc(1'b0, 1'b1, 3'b111);
    chk("tri.pend_c1", 32'(pend0), 32'(3'b111));
    for (int e = 1; e <= 20; e++) begin
      cyc(1'b0, 1'b1, 3'b000);
      if (e + 1 == 2)  begin chk("tri.act_c2",  32'({e0, s0, c0}), 32'(3'b001));
                             chk("tri.pend_c2", 32'(pend0), 32'(3'b110)); end
      if (e + 1 == 9)  chk("tri.act_c9",  32'({e0, s0, c0}), 32'(3'b000));
      if (e + 1 == 10) begin chk("tri.act_c10",  32'({e0, s0, c0}), 32'(3'b010));
                             chk("tri.pend_c10", 32'(pend0), 32'(3'b100)); end
      if (e + 1 == 17) chk("tri.act_c17", 32'({e0, s0, c0}), 32'(3'b000));
      if (e + 1 == 18) begin chk("tri.act_c18",  32'({e0, s0, c0}), 32'(3'b100));
                             chk("tri.pend_c18", 32'(pend0), 32'(3'b000)); end
    end

    // No gap on u1: C then S, with exactly one idle cycle between pulses.
    cyc(1'b1, 1'b1, 3'b000);
    cyc(1'b0, 1'b1, 3'b011);
    for (int e = 1; e <= 10; e++) begin
      cyc(1'b0, 1'b1, 3'b000);
      if (e + 1 == 4) chk("gap0.act_c4", 32'({e1, s1, c1}), 32'(3'b001));
      if (e + 1 == 5) begin chk("gap0.act_c5",  32'({e1, s1, c1}), 32'(3'b000));
                            chk("gap0.done_c5", 32'({done1, did1}), 32'(3'b101)); end
      if (e + 1 == 6) chk("gap0.act_c6", 32'({e1, s1, c1}), 32'(3'b010));
      if (e + 1 == 9) chk("gap0.done_c9", 32'({done1, did1}), 32'(3'b110));
    end

    // Slow tick (every 4th cycle): pulse spans PULSE_TICKS tick edges.
    cyc(1'b1, 1'b1, 3'b000);
    ticks_hi0 = 0; ticks_hi1 = 0; bad_chg = 0;
    for (int e = 0; e < 44; e++) begin
      logic t;
      t = (e % 4 == 3);
      prev0 = {e0, s0, c0};
      prev1 = {e1, s1, c1};
      cyc(1'b0, t, (e == 0) ? 3'b001 : 3'b000);
      if (t && prev0 != 0) ticks_hi0++;
      if (t && prev1 != 0) ticks_hi1++;
      if (!t && prev0 != 0 && prev0 != {e0, s0, c0}) bad_chg++;
      if (!t && prev1 != 0 && prev1 != {e1, s1, c1}) bad_chg++;
    end
    chk("slow.ticks_u0", 32'(ticks_hi0), 32'd5);
    chk("slow.ticks_u1", 32'(ticks_hi1), 32'd3);
    chk("slow.nontick_chg", 32'(bad_chg), 32'd0);

    // Overrun: repeat during the pulse is fine, a second one while pending is not.
    TICK = 1'b1;
    cyc(1'b1, 1'b1, 3'b000);
    s_dones = 0;
    for (int e = 0; e <= 30; e++) begin
      cyc(1'b0, 1'b1, (e == 0 || e == 3 || e == 4) ? 3'b010 : 3'b000);
      if (done0 && did0 == 2'b10) s_dones++;
      if (e == 3) begin chk("ovr.pend_e3", 32'(pend0), 32'(3'b010));
                        chk("ovr.ovr_e3",  32'(ovr0),  32'd0); end
      if (e == 4) chk("ovr.ovr_e4", 32'(ovr0), 32'd1);
    end
    chk("ovr.s_dones", 32'(s_dones), 32'd2);
    chk("ovr.sticky",  32'(ovr0),    32'd1);

    // Reset in the third cycle of an eject pulse with C and S pending.
    cyc(1'b1, 1'b1, 3'b000);
    cyc(1'b0, 1'b1, 3'b100);
    cyc(1'b0, 1'b1, 3'b000);
    cyc(1'b0, 1'b1, 3'b011);
    cyc(1'b0, 1'b1, 3'b000);
    chk("rst.act_before",  32'({e0, s0, c0}), 32'(3'b100));
    chk("rst.pend_before", 32'(pend0), 32'(3'b011));
    cyc(1'b1, 1'b1, 3'b000);
    chk("rst.act",  32'({e0, s0, c0}), 32'(3'b000));
    chk("rst.pend", 32'(pend0), 32'(3'b000));
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.ovr",  32'(ovr0),  32'd0);
    cyc(1'b0, 1'b1, 3'b100);
    chk("rst.req_lat1", 32'({e0, s0, c0}), 32'(3'b000));
    cyc(1'b0, 1'b1, 3'b000);
    chk("rst.req_lat2", 32'({e0, s0, c0}), 32'(3'b100));

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic r, t;
      logic [2:0] q;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) != 0);
      q = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      cyc(r, t, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
